// File: rtl/svc_rv_store_buf_pkg.sv
// Shared RV data-path constants used by the store buffer and its forwarding merge.
package svc_rv_store_buf_pkg;

   localparam int unsigned RV_DATA_W   = 32;
   localparam int unsigned RV_STRB_W   = 4;
   localparam int unsigned RV_WORD_OFF = 2;

   // Expand a byte-strobe vector into a 32-bit byte mask.
   function automatic logic [RV_DATA_W-1:0] strb_to_mask(input logic [RV_STRB_W-1:0] strb);
      logic [RV_DATA_W-1:0] mask;
      mask = '0;
      for (int unsigned b = 0; b < RV_STRB_W; b++) begin
         mask[8*b +: 8] = {8{strb[b]}};
      end
      return mask;
   endfunction

endpackage

// File: rtl/svc_rv_store_buf_fwd.sv
// Byte-lane priority merge: entries arrive oldest-first, so later (younger) matches win each lane.
module svc_rv_store_buf_fwd
   import svc_rv_store_buf_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic [DEPTH-1:0]                     match_i,
   input  logic [DEPTH-1:0][RV_STRB_W-1:0]      strb_i,
   input  logic [DEPTH-1:0][RV_DATA_W-1:0]      data_i,
   output logic [RV_STRB_W-1:0]                 covered_c_o,
   output logic [RV_DATA_W-1:0]                 data_c_o
);

   always_comb begin
      covered_c_o = '0;
      data_c_o    = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         for (int unsigned b = 0; b < RV_STRB_W; b++) begin
            if (match_i[k] && strb_i[k][b]) begin
               covered_c_o[b]    = 1'b1;
               data_c_o[8*b +: 8] = data_i[k][8*b +: 8];
            end
         end
      end
   end

endmodule

// File: rtl/svc_rv_store_buf.sv
// In-order store buffer between MEM and the data-memory write port, with load
// forwarding on full coverage and a stall request on partial overlap.
module svc_rv_store_buf
   import svc_rv_store_buf_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned XLEN  = 32
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         st_valid,
   output logic                         st_ready,
   input  logic [XLEN-1:0]              st_addr,
   input  logic [RV_DATA_W-1:0]         st_data,
   input  logic [RV_STRB_W-1:0]         st_strb,
   input  logic                         ld_valid,
   input  logic [XLEN-1:0]              ld_addr,
   input  logic [RV_STRB_W-1:0]         ld_strb,
   output logic                         ld_hit,
   output logic [RV_DATA_W-1:0]         ld_data,
   output logic                         ld_stall,
   output logic                         mem_wr_valid,
   input  logic                         mem_wr_ready,
   output logic [XLEN-1:0]              mem_wr_addr,
   output logic [RV_DATA_W-1:0]         mem_wr_data,
   output logic [RV_STRB_W-1:0]         mem_wr_strb,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned AW  = $clog2(DEPTH);
   localparam int unsigned PW  = AW + 1;
   localparam int unsigned CW  = $clog2(DEPTH+1);
   localparam int unsigned WAW = XLEN - RV_WORD_OFF;

   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [WAW-1:0]        addr_q [DEPTH];
   logic [RV_DATA_W-1:0]  data_q [DEPTH];
   logic [RV_STRB_W-1:0]  strb_q [DEPTH];

   logic                  full;
   logic                  push;
   logic                  pop;
   logic [AW-1:0]         rd_idx;
   logic [AW-1:0]         wr_idx;

   assign wr_idx = wr_ptr_q[AW-1:0];
   assign rd_idx = rd_ptr_q[AW-1:0];

   // Extra pointer MSB distinguishes full from empty when the index bits meet.
   assign full     = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) && (wr_idx == rd_idx);
   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign count    = CW'(wr_ptr_q - rd_ptr_q);
   assign st_ready = !full;
   assign push     = st_valid && !full;
   assign pop      = !empty && mem_wr_ready;

   assign wr_ptr_d = wr_ptr_q + PW'(push);
   assign rd_ptr_d = rd_ptr_q + PW'(pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Payload storage is deliberately left out of reset; validity comes from the pointers.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[wr_idx] <= st_addr[XLEN-1:RV_WORD_OFF];
         data_q[wr_idx] <= st_data;
         strb_q[wr_idx] <= st_strb;
      end
   end

   assign mem_wr_valid = !empty;
   assign mem_wr_addr  = {addr_q[rd_idx], {RV_WORD_OFF{1'b0}}};
   assign mem_wr_data  = data_q[rd_idx];
   assign mem_wr_strb  = strb_q[rd_idx];

   logic [DEPTH-1:0]                  age_match;
   logic [DEPTH-1:0][RV_STRB_W-1:0]   age_strb;
   logic [DEPTH-1:0][RV_DATA_W-1:0]   age_data;

   // Rotate the ring into age order (slot 0 = head) so the merge can use fixed priority.
   always_comb begin
      logic [AW-1:0] idx;
      idx       = '0;
      age_match = '0;
      age_strb  = '0;
      age_data  = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         idx          = rd_idx + AW'(k);
         age_strb[k]  = strb_q[idx];
         age_data[k]  = data_q[idx];
         age_match[k] = (CW'(k) < count) && (addr_q[idx] == ld_addr[XLEN-1:RV_WORD_OFF]);
      end
   end

   logic [RV_STRB_W-1:0]  covered;
   logic [RV_DATA_W-1:0]  fwd_data;
   logic [RV_STRB_W-1:0]  req_cov;
   logic [RV_STRB_W-1:0]  req_miss;

   svc_rv_store_buf_fwd #(
      .DEPTH (DEPTH)
   ) u_fwd (
      .match_i     (age_match),
      .strb_i      (age_strb),
      .data_i      (age_data),
      .covered_c_o (covered),
      .data_c_o    (fwd_data)
   );

   assign req_cov  = ld_strb & covered;
   assign req_miss = ld_strb & ~covered;

   assign ld_hit   = ld_valid && (|req_cov) && !(|req_miss);
   assign ld_stall = ld_valid && (|req_cov) && (|req_miss);
   assign ld_data  = fwd_data & strb_to_mask(req_cov);

   logic unused_addr_lsbs;
   assign unused_addr_lsbs = ^{st_addr[RV_WORD_OFF-1:0], ld_addr[RV_WORD_OFF-1:0]};

endmodule

// File: tb/tb_svc_rv_store_buf.sv
// Bench for svc_rv_store_buf: directed scenarios then random traffic against a queue model.
module tb_svc_rv_store_buf;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        st_valid;
   logic        st_ready;
   logic [31:0] st_addr;
   logic [31:0] st_data;
   logic [3:0]  st_strb;
   logic        ld_valid;
   logic [31:0] ld_addr;
   logic [3:0]  ld_strb;
   logic        ld_hit;
   logic [31:0] ld_data;
   logic        ld_stall;
   logic        mem_wr_valid;
   logic        mem_wr_ready;
   logic [31:0] mem_wr_addr;
   logic [31:0] mem_wr_data;
   logic [3:0]  mem_wr_strb;
   logic        empty;
   logic [2:0]  count;

   always #5 clk = ~clk;

   svc_rv_store_buf #(.DEPTH(DEPTH), .XLEN(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .st_valid     (st_valid),
      .st_ready     (st_ready),
      .st_addr      (st_addr),
      .st_data      (st_data),
      .st_strb      (st_strb),
      .ld_valid     (ld_valid),
      .ld_addr      (ld_addr),
      .ld_strb      (ld_strb),
      .ld_hit       (ld_hit),
      .ld_data      (ld_data),
      .ld_stall     (ld_stall),
      .mem_wr_valid (mem_wr_valid),
      .mem_wr_ready (mem_wr_ready),
      .mem_wr_addr  (mem_wr_addr),
      .mem_wr_data  (mem_wr_data),
      .mem_wr_strb  (mem_wr_strb),
      .empty        (empty),
      .count        (count)
   );

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
   } ent_t;

   ent_t q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Pending stores are a program-order list; a load byte comes from the newest store to that word that writes it.
   task automatic check_model();
      logic [3:0]  cov;
      logic [31:0] d;
      chk("count", 32'(count), 32'(q.size()));
      chk("empty", 32'(empty), 32'(q.size() == 0));
      chk("st_ready", 32'(st_ready), 32'(q.size() < DEPTH));
      chk("mem_wr_valid", 32'(mem_wr_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
         chk("mem_wr_addr", mem_wr_addr, q[0].addr);
         chk("mem_wr_data", mem_wr_data, q[0].data);
         chk("mem_wr_strb", 32'(mem_wr_strb), 32'(q[0].strb));
      end
      if (ld_valid) begin
         cov = '0;
         d   = '0;
         for (int b = 0; b < 4; b++) begin
            if (ld_strb[b]) begin
               for (int i = q.size() - 1; i >= 0; i--) begin
                  if (q[i].addr[31:2] == ld_addr[31:2] && q[i].strb[b]) begin
                     cov[b]       = 1'b1;
                     d[8*b +: 8]  = q[i].data[8*b +: 8];
                     break;
                  end
               end
            end
         end
         chk("ld_hit", 32'(ld_hit), 32'(cov != 4'd0 && cov == ld_strb));
         chk("ld_stall", 32'(ld_stall), 32'(cov != 4'd0 && cov != ld_strb));
         chk("ld_data", ld_data, d);
      end
   endtask

   task automatic settle();
      @(negedge clk);
      check_model();
   endtask

   task automatic tick();
      bit do_pop;
      bit do_push;
      @(posedge clk);
      if (rst) begin
         q.delete();
      end else begin
         do_pop  = (q.size() != 0) && mem_wr_ready;
         do_push = st_valid && (q.size() < DEPTH);
         if (do_pop) void'(q.pop_front());
         if (do_push) q.push_back('{addr: st_addr & ~32'h3, data: st_data, strb: st_strb});
      end
      #1;
   endtask

   task automatic drive(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                        input logic [3:0] ss, input logic lv, input logic [31:0] la,
                        input logic [3:0] ls, input logic rdy);
      st_valid     = sv;
      st_addr      = sa;
      st_data      = sd;
      st_strb      = ss;
      ld_valid     = lv;
      ld_addr      = la;
      ld_strb      = ls;
      mem_wr_ready = rdy;
   endtask

   logic [31:0] exp_seq [8];
   logic [31:0] next_addr;

   initial begin
      exp_seq = '{32'h500, 32'h504, 32'h508, 32'h50C, 32'h600, 32'h604, 32'h608, 32'h60C};

      // Reset
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 1, 32'h100, 4'hF, 0);
      settle();
      chk("rst_ld_hit", 32'(ld_hit), 32'd0);
      chk("rst_ld_stall", 32'(ld_stall), 32'd0);
      tick();
      rst = 1'b0;

      // Single full-word store forwarded while memory is busy
      drive(1, 32'h100, 32'hAABBCCDD, 4'hF, 0, 0, 0, 0);
      settle(); tick();
      drive(0, 0, 0, 0, 1, 32'h100, 4'hF, 0);
      settle();
      chk("fwd_hit", 32'(ld_hit), 32'd1);
      chk("fwd_data", ld_data, 32'hAABBCCDD);
      chk("fwd_count", 32'(count), 32'd1);
      chk("fwd_mvalid", 32'(mem_wr_valid), 32'd1);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 1);
      settle(); tick();

      // Partial overlap stalls until the entry drains
      drive(1, 32'h200, 32'hDEAD1234, 4'b0011, 0, 0, 0, 0);
      settle(); tick();
      drive(0, 0, 0, 0, 1, 32'h200, 4'hF, 1);
      settle();
      chk("part_stall", 32'(ld_stall), 32'd1);
      chk("part_hit", 32'(ld_hit), 32'd0);
      tick();
      drive(0, 0, 0, 0, 1, 32'h200, 4'hF, 0);
      settle();
      chk("part_stall_after", 32'(ld_stall), 32'd0);
      chk("part_empty_after", 32'(empty), 32'd1);
      tick();

      // Youngest store wins per byte lane
      drive(1, 32'h300, 32'h11111111, 4'hF, 0, 0, 0, 0);
      settle(); tick();
      drive(1, 32'h300, 32'h00220000, 4'b0100, 0, 0, 0, 0);
      settle(); tick();
      drive(0, 0, 0, 0, 1, 32'h300, 4'hF, 0);
      settle();
      chk("young_hit", 32'(ld_hit), 32'd1);
      chk("young_data", ld_data, 32'h11221111);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) begin settle(); tick(); end

      // Fill, reject a fifth store, then stream through with pointer wrap
      for (int i = 0; i < DEPTH; i++) begin
         drive(1, 32'h500 + 32'(4 * i), $urandom, 4'hF, 0, 0, 0, 0);
         settle(); tick();
      end
      drive(1, 32'h5F0, 32'hBAD0BAD0, 4'hF, 0, 0, 0, 0);
      settle();
      chk("full_st_ready", 32'(st_ready), 32'd0);
      tick();
      next_addr = 32'h600;
      for (int c = 0; c < 8; c++) begin
         bit acc;
         drive(1, next_addr, $urandom, 4'hF, 1, 32'h500 + 32'(4 * (c % 4)), 4'hF, 1);
         settle();
         chk("drain_order", mem_wr_addr, exp_seq[c]);
         if (c == 0) chk("full_drain_st_ready", 32'(st_ready), 32'd0);
         acc = q.size() < DEPTH;
         tick();
         if (acc) next_addr = next_addr + 32'd4;
      end
      drive(0, 0, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 6; i++) begin settle(); tick(); end

      // Reset discards pending entries
      for (int i = 0; i < 3; i++) begin
         drive(1, 32'h700 + 32'(4 * i), $urandom, 4'hF, 0, 0, 0, 0);
         settle(); tick();
      end
      rst = 1'b1;
      drive(0, 0, 0, 0, 1, 32'h700, 4'hF, 0);
      settle(); tick();
      rst = 1'b0;
      settle();
      chk("mrst_empty", 32'(empty), 32'd1);
      chk("mrst_mvalid", 32'(mem_wr_valid), 32'd0);
      chk("mrst_count", 32'(count), 32'd0);
      chk("mrst_hit", 32'(ld_hit), 32'd0);
      chk("mrst_stall", 32'(ld_stall), 32'd0);
      tick();

      // Neighbouring word must not match
      drive(1, 32'h404, 32'h55667788, 4'hF, 0, 0, 0, 0);
      settle(); tick();
      drive(0, 0, 0, 0, 1, 32'h400, 4'hF, 0);
      settle();
      chk("word_hit", 32'(ld_hit), 32'd0);
      chk("word_stall", 32'(ld_stall), 32'd0);
      tick();

      // Random traffic over a few colliding words
      for (int c = 0; c < 500; c++) begin
         rst = ($urandom_range(63) == 0);
         drive(1'($urandom_range(1)),
               32'h100 + 32'(4 * $urandom_range(2)) + 32'($urandom_range(3)),
               $urandom, 4'($urandom_range(15)),
               1'($urandom_range(1)),
               32'h100 + 32'(4 * $urandom_range(2)) + 32'($urandom_range(3)),
               4'($urandom_range(15)),
               1'($urandom_range(3) == 0));
         settle(); tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
